// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, boot vector, bubble word.
package pipeline_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC   = 32'hBFC0_0000;
   localparam logic [XLEN-1:0] NOP_WORD   = 32'h0000_0000;
   localparam logic [XLEN-1:0] PC_INC     = 32'd4;
   localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      KILL  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_buf.sv
// Single-entry fetch output buffer feeding the IF/ID register.
module if_fetch_buf #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_pc,
   input  logic [31:0] load_ins,
   input  logic        consume,
   input  logic        flush,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_ins
);

   // Flush beats a fresh load; a load replaces whatever is being consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_valid <= 1'b0;
         if_pc    <= RESET_PC;
         if_ins   <= NOP_WORD;
      end else if (flush) begin
         if_valid <= 1'b0;
         if_ins   <= NOP_WORD;
      end else if (load) begin
         if_valid <= 1'b1;
         if_pc    <= load_pc;
         if_ins   <= load_ins;
      end else if (consume) begin
         if_valid <= 1'b0;
         if_ins   <= NOP_WORD;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and the imem handshake.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = pipeline_pkg::RESET_PC,
   parameter logic [31:0] NOP_WORD = pipeline_pkg::NOP_WORD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_ins,
   output logic        if_valid,
   output logic        if_stall
);

   import pipeline_pkg::*;

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            buf_free_c;
   logic            buf_load_c;
   logic            buf_consume_c;

   // Entry is free when empty or being handed to IF/ID at this edge.
   assign buf_free_c    = !if_valid || !stall_i;
   assign buf_consume_c = if_valid && !stall_i;
   assign imem_addr     = {pc_q[XLEN-1:2], 2'b00};
   assign if_stall      = stall_i;

   // State and PC registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state, next PC and request; redirect overrides capture and stall.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      imem_req   = 1'b0;
      buf_load_c = 1'b0;

      case (state_q)
         FETCH: begin
            imem_req = buf_free_c;
            if (imem_req && imem_gnt) begin
               state_d = redirect_i ? KILL : WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_d = FETCH;
               if (!redirect_i) begin
                  buf_load_c = 1'b1;
                  pc_d       = pc_q + PC_INC;
               end
            end else if (redirect_i) begin
               state_d = KILL;
            end
         end
         KILL: begin
            if (imem_rvalid) begin
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      if (redirect_i) begin
         pc_d = redirect_pc_i & ALIGN_MASK;
      end

      // Memory shares reset; never present a request while it is held.
      if (rst) begin
         imem_req = 1'b0;
      end
   end

   if_fetch_buf #(
      .RESET_PC (RESET_PC),
      .NOP_WORD (NOP_WORD)
   ) u_buf (
      .clk      (clk),
      .rst      (rst),
      .load     (buf_load_c),
      .load_pc  (pc_q),
      .load_ins (imem_rdata),
      .consume  (buf_consume_c),
      .flush    (redirect_i),
      .if_valid (if_valid),
      .if_pc    (if_pc),
      .if_ins   (if_ins)
   );

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of the IF/ID pipeline register and owns the PC register and next-PC selection. It runs a request/grant/response handshake to instruction memory, which may insert wait states. It presents one fetched instruction (or a NOP bubble) per consumed slot, together with the stall signal the IF/ID register samples.

Parameters:
RESET_PC, 32'hBFC0_0000, PC value loaded on reset (boot vector)
NOP_WORD, 32'h0000_0000, instruction word driven when no valid instruction is held (sll $0,$0,0)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, synchronous, active-high
stall_i  in  1  hazard-unit freeze of IF/ID and later stages
redirect_i  in  1  single-cycle pulse: branch/jump/exception redirect
redirect_pc_i  in  32  target PC, valid with redirect_i
imem_req  out  1  memory request valid
imem_addr  out  32  word-aligned fetch address
imem_gnt  in  1  memory accepted request this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  32  instruction word
if_pc  out  32  PC of presented instruction, to IF/ID
if_ins  out  32  presented instruction, to IF/ID
if_valid  out  1  if_ins is a real fetched instruction
if_stall  out  1  to IF/ID: hold contents this edge

Behaviour:
- Reset, synchronous: pc=RESET_PC, state=FETCH, if_valid=0, if_pc=RESET_PC, if_ins=NOP_WORD, imem_req=0 in the reset cycle. Instruction memory shares rst, so no response is delivered for a pre-reset request.
- States: FETCH (request pending), WAIT (granted, awaiting rvalid), KILL (granted request squashed, discard its response).
- Buffer: one entry {if_valid, if_pc, if_ins}. The entry is "free" if if_valid=0, or if if_valid=1 and stall_i=0 (it is consumed at this edge).
- FETCH: imem_req = buffer free; imem_addr = {pc[31:2],2'b00}. When imem_req and imem_gnt are both high, go to WAIT.
- WAIT: imem_req=0. On imem_rvalid: load buffer (if_valid=1, if_pc=pc, if_ins=imem_rdata), set pc=pc+4 (32-bit wrap, carry ignored), go to FETCH.
- Throughput with zero-wait memory (gnt same cycle, rvalid next cycle): one instruction per 2 cycles. Only one request is outstanding at any time.
- Consumption: when if_valid=1 and stall_i=0 and no new response arrives, clear if_valid and set if_ins=NOP_WORD. if_pc holds its value.
- if_stall = stall_i, combinational. IF/ID therefore loads a bubble when nothing is valid and freezes only on a hazard stall.
- While stall_i=1 and if_valid=1, the buffer holds and no new request is issued.
- Redirect has priority over stall_i and over response capture. In the cycle redirect_i=1:
  - pc=redirect_pc_i with bits[1:0] forced to 0.
  - if_valid=0 and if_ins=NOP_WORD.
  - From FETCH with gnt in the same cycle: go to KILL.
  - From FETCH without gnt: stay in FETCH; the next request uses the new pc.
  - From WAIT without rvalid: go to KILL.
  - From WAIT with rvalid in the same cycle: drop the data, go to FETCH.
  - From KILL: stay in KILL; the new pc replaces the old.
- KILL: imem_req=0. On imem_rvalid, discard the data and go to FETCH. pc is unchanged by the discarded response.
- Delay slots: this block squashes everything it holds on redirect. The redirect source issues redirect_i only after the delay-slot instruction has left IF/ID.
- rst asserted in any state overrides all other inputs.

Decomposition:
- Shared package (pipeline_pkg):
  - fetch-state enum {FETCH, WAIT, KILL}
  - RESET_PC, NOP_WORD
  - PC increment constant 32'd4
- One sub-module, if_fetch_buf: the single-entry output buffer with load, consume and flush controls.
- The FSM and pc register stay in if_fetch_stage.

Test Plan:
1. Reset, then memory gnt=1 every cycle and rvalid one cycle after grant. Required: imem_addr sequence BFC00000, BFC00004, BFC00008. if_valid pulses every second cycle, with if_pc matching each address.
2. Memory delays gnt by 3 cycles for address BFC00004. Required: imem_req stays high with the address stable. The buffer shows NOP_WORD with if_valid=0 until rvalid arrives, then loads the instruction.
3. stall_i=1 for 4 cycles while the buffer holds if_pc=BFC00008. Required: if_stall=1, buffer unchanged, imem_req=0. After release, the next request is to BFC0000C.
4. redirect_i with redirect_pc_i=80001003 arriving in WAIT, no rvalid. Required: state goes to KILL and the next rvalid data is discarded (if_valid stays 0). The next imem_addr is 80001000.
5. redirect_i in the same cycle as rvalid in WAIT, plus stall_i=1. Required: the response is dropped, if_valid=0, and the next cycle requests redirect_pc_i.
6. rst asserted mid-WAIT with pc=80001010. Required: next cycle pc=BFC00000, if_valid=0, state FETCH, and the next imem_addr is BFC00000.
